// File: rtl/mips_rf_pkg.sv
// Shared types and helpers for the multi-port MIPS register file.
package mips_rf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned MAX_WR     = 4;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t DumpIdle   = 2'd0;
  localparam dump_state_t DumpStream = 2'd1;
  localparam dump_state_t DumpDone   = 2'd2;

  // Returns {found, port}; the highest-numbered hitting port wins.
  function automatic logic [2:0] wr_winner(input logic [MAX_WR-1:0] hit);
    logic [2:0] res;
    res = '0;
    for (int w = 0; w < int'(MAX_WR); w++) begin
      if (hit[w]) res = {1'b1, 2'(w)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile_mp_dump_fsm.sv
// Dump engine: streams every register over a valid/ready channel after a dump_req pulse.
module mips_rf_dump_fsm
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] rd_num,
  input  logic [DATA_W-1:0] rd_data
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cap_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_en  = 1'b0;
    unique case (state_q)
      DumpIdle: begin
        if (dump_req) begin
          state_d = DumpStream;
          idx_d   = '0;
          cap_en  = 1'b1;
        end
      end
      DumpStream: begin
        if (dump_ready) begin
          if (idx_q == {ADDR_W{1'b1}}) begin
            state_d = DumpDone;
          end else begin
            idx_d  = idx_q + 1'b1;
            cap_en = 1'b1;
          end
        end
      end
      default: state_d = DumpIdle;
    endcase
  end

  // The capture reads the index being moved to; flop storage yields the pre-write value.
  assign rd_num = idx_d;
  assign data_d = cap_en ? rd_data : data_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= DumpIdle;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == DumpStream);
  assign dump_busy  = (state_q != DumpIdle);
  assign dump_done  = (state_q == DumpDone);
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-port MIPS register file with r0 hardwired to zero and a hardware dump port.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module mips_regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_num,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we    [DEPTH];
  logic [DATA_W-1:0] wd    [DEPTH];
  logic [MAX_WR-1:0] hit;
  logic [2:0]        win;

  // Per-entry write arbitration; shared by storage update and bypass.
  always_comb begin
    hit = '0;
    win = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit = '0;
      for (int w = 0; w < int'(NUM_WR); w++) begin
        hit[w] = wr_en[w] && (wr_num[w*ADDR_W +: ADDR_W] == ADDR_W'(i)) && (i != 0);
      end
      win   = wr_winner(hit);
      we[i] = win[2];
      wd[i] = wr_data[int'(win[1:0])*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (we[i]) mem_q[i] <= wd[i];
      end
    end
  end

  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    rd_data = '0;
    rd_idx  = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      rd_idx = rd_num[p*ADDR_W +: ADDR_W];
      if (rd_idx == '0) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else begin
`ifdef RF_BYPASS_EN
        rd_data[p*DATA_W +: DATA_W] = we[rd_idx] ? wd[rd_idx] : mem_q[rd_idx];
`else
        rd_data[p*DATA_W +: DATA_W] = mem_q[rd_idx];
`endif
      end
    end
  end

  logic [ADDR_W-1:0] dump_rd_num;
  logic [DATA_W-1:0] dump_rd_data;

  // The dump path reads storage directly and never sees forwarded data.
  assign dump_rd_data = mem_q[dump_rd_num];

  mips_rf_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clk        (clk),
    .rst_b      (rst_b),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .rd_num     (dump_rd_num),
    .rd_data    (dump_rd_data)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (NUM_WR=2, NUM_RD=2).
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [9:0]  rd_num;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_num;
  logic [63:0] wr_data;
  logic        dump_req, dump_valid, dump_ready, dump_busy, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mips_regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2),
    .NUM_WR (2)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .rd_num     (rd_num),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_num     (wr_num),
    .wr_data    (wr_data),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic wr2(input bit e0, input int n0, input logic [31:0] d0,
                     input bit e1, input int n1, input logic [31:0] d1);
    wr_en   = {e1, e0};
    wr_num  = {5'(n1), 5'(n0)};
    wr_data = {d1, d0};
  endtask

  task automatic wr_off();
    wr_en = 2'b00;
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  logic [31:0] exp_w;

  initial begin
    rst_b = 1'b0; rd_num = '0; wr_en = '0; wr_num = '0; wr_data = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    #12;
    chk("rst_valid", {31'b0, dump_valid}, 32'd0);
    chk("rst_busy",  {31'b0, dump_busy},  32'd0);
    chk("rst_done",  {31'b0, dump_done},  32'd0);
    chk("rst_idx",   {27'b0, dump_idx},   32'd0);
    chk("rst_data",  dump_data,           32'd0);
    rst_b = 1'b1;
    tick();

    // r5 write plus a dropped r0 write
    wr2(1, 5, 32'hDEADBEEF, 1, 0, 32'h1234);
    tick();
    wr_off();
    rd_num = {5'd0, 5'd5};
    #1;
    chk("rd_r5", rd_data[31:0],  32'hDEADBEEF);
    chk("rd_r0", rd_data[63:32], 32'd0);

    // Same-index conflict: port 1 wins
    wr2(1, 7, 32'h11, 1, 7, 32'h22);
    tick();
    wr_off();
    rd_num = {5'd5, 5'd7};
    #1;
    chk("conflict_r7", rd_data[31:0],  32'h22);
    chk("keep_r5",     rd_data[63:32], 32'hDEADBEEF);

    // Same-cycle write/read of r3; r0 forwarding must still give 0
    wr2(1, 3, 32'hA5A5A5A5, 1, 0, 32'h5);
    rd_num = {5'd0, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    exp_w = 32'hA5A5A5A5;
`else
    exp_w = 32'h0;
`endif
    chk("same_cycle_r3", rd_data[31:0],  exp_w);
    chk("same_cycle_r0", rd_data[63:32], 32'd0);
    tick();
    wr_off();
    #1;
    chk("after_r3", rd_data[31:0], 32'hA5A5A5A5);

    // Preload r[i] = i*3 using both ports
    for (int i = 1; i < 32; i += 2) begin
      wr2(1, i, 32'(i * 3), (i + 1) < 32, (i + 1) % 32, 32'((i + 1) * 3));
      tick();
    end
    wr_off();

    // Full dump, ready held high
    dump_ready = 1'b1;
    start_dump();
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("d1_valid_%0d", k), {31'b0, dump_valid}, 32'd1);
      chk($sformatf("d1_idx_%0d", k),   {27'b0, dump_idx},   32'(k));
      chk($sformatf("d1_data_%0d", k),  dump_data,           32'(k * 3));
      tick();
    end
    chk("d1_done",      {31'b0, dump_done},  32'd1);
    chk("d1_done_busy", {31'b0, dump_busy},  32'd1);
    chk("d1_done_vld",  {31'b0, dump_valid}, 32'd0);
    tick();
    chk("d1_done_pulse", {31'b0, dump_done}, 32'd0);
    chk("d1_idle_busy",  {31'b0, dump_busy}, 32'd0);

    // Dump with a 5-cycle stall at idx 10 and writes during the stall
    start_dump();
    for (int k = 0; k < 10; k++) tick();
    dump_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s == 0) wr2(1, 10, 32'hFF, 0, 0, 32'h0);
      else if (s == 1) wr2(1, 20, 32'hEE, 0, 0, 32'h0);
      else wr_off();
      chk($sformatf("stall_idx_%0d", s),  {27'b0, dump_idx}, 32'd10);
      chk($sformatf("stall_data_%0d", s), dump_data,         32'd30);
      chk($sformatf("stall_vld_%0d", s),  {31'b0, dump_valid}, 32'd1);
      tick();
    end
    wr_off();
    dump_ready = 1'b1;
    for (int k = 10; k < 32; k++) begin
      exp_w = (k == 20) ? 32'hEE : 32'(k * 3);
      chk($sformatf("d2_idx_%0d", k),  {27'b0, dump_idx}, 32'(k));
      chk($sformatf("d2_data_%0d", k), dump_data,         exp_w);
      tick();
    end
    chk("d2_done", {31'b0, dump_done}, 32'd1);
    tick();
    rd_num = {5'd20, 5'd10};
    #1;
    chk("rd_r10_ff", rd_data[31:0],  32'hFF);
    chk("rd_r20_ee", rd_data[63:32], 32'hEE);

    // Reset mid-dump at idx 12
    start_dump();
    for (int k = 0; k < 12; k++) tick();
    chk("pre_rst_idx", {27'b0, dump_idx}, 32'd12);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_valid", {31'b0, dump_valid}, 32'd0);
    chk("arst_busy",  {31'b0, dump_busy},  32'd0);
    chk("arst_idx",   {27'b0, dump_idx},   32'd0);
    chk("arst_data",  dump_data,           32'd0);
    chk("arst_done",  {31'b0, dump_done},  32'd0);
    tick();
    chk("arst_done2", {31'b0, dump_done}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("post_rst_done", {31'b0, dump_done}, 32'd0);
    chk("post_rst_r10",  rd_data[31:0],      32'd0);

    start_dump();
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("d3_idx_%0d", k),  {27'b0, dump_idx}, 32'(k));
      chk($sformatf("d3_data_%0d", k), dump_data,         32'd0);
      tick();
    end
    chk("d3_done", {31'b0, dump_done}, 32'd1);
    tick();
    chk("d3_idle", {31'b0, dump_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-port register file for the MIPS core, the successor to the fixed 2-read/1-write, 32×32 file. It provides NUM_RD combinational read ports and NUM_WR prioritised write ports, and keeps location 0 hardwired to zero. A hardware dump engine streams the whole file out over a valid/ready channel on request, which replaces the simulation-only halt dump. It sits in the decode stage (reads) and the writeback stage (writes); the dump channel feeds the debug/trace unit.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write ports (1..4)

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- rd_num  input  NUM_RD*ADDR_W  read indices; port p occupies [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, packed the same way
- wr_en  input  NUM_WR  per-port write enable
- wr_num  input  NUM_WR*ADDR_W  write indices
- wr_data  input  NUM_WR*DATA_W  write data
- dump_req  input  1  one-cycle start pulse for a dump
- dump_valid  output  1  dump word is presented
- dump_ready  input  1  consumer accepts the dump word
- dump_idx  output  ADDR_W  index of the presented word
- dump_data  output  DATA_W  snapshot of the presented word
- dump_busy  output  1  dump engine is not IDLE
- dump_done  output  1  one-cycle pulse after the last word is accepted

## Operation
- Reset: every entry is set to 0. dump_valid, dump_busy and dump_done are 0. dump_idx and dump_data are 0. The FSM is in IDLE.
- Writes: at posedge clk, each port with wr_en=1 and wr_num!=0 writes its wr_data. Writes to index 0 are dropped.
- Write conflicts: if several ports target the same index in one cycle, the highest-numbered port wins.
- Reads: combinational. rd_data[p] = 0 when rd_num[p]==0, otherwise the stored entry (see Configuration for same-cycle writes).
- Dump FSM states are IDLE, STREAM and DONE.
  - IDLE: a dump_req pulse moves the FSM to STREAM, sets dump_idx=0 and captures dump_data=0.
  - STREAM: dump_valid=1 and dump_busy=1. When dump_valid&&dump_ready: if dump_idx==DEPTH-1, go to DONE; otherwise increment dump_idx and capture dump_data from the stored entry at the new index.
  - DONE: dump_done=1 and dump_busy=1 for exactly one cycle, then return to IDLE.
- dump_req is ignored in STREAM and DONE. It is never queued.
- Writes are fully allowed during a dump. A word already captured does not change while it is stalled. Entries not yet captured reflect writes made before their capture edge.
- Reset asserted mid-dump aborts the dump immediately: FSM goes to IDLE with all outputs at their reset values, and no dump_done is issued.

## Timing
- Read latency is 0 cycles (combinational from rd_num).
- A write is visible to reads in the cycle after the write edge, or in the same cycle with bypass enabled.
- Dump handshake:
  - dump_valid rises in the cycle after dump_req.
  - Throughput is one word per cycle while dump_ready=1, so a full dump takes DEPTH+2 cycles from dump_req to dump_done.
  - dump_idx and dump_data stay stable while dump_valid=1 and dump_ready=0.
- The capture edge reads the pre-write value of the entry when a write to that same index occurs on that same edge.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: a read port whose index matches an active write this cycle (wr_en=1, wr_num!=0) returns that port's wr_data, using the winning (highest-numbered) port. Index 0 still reads 0.
- Not defined: reads always return the stored value. Same-cycle writes are not forwarded.
- The dump path never bypasses in either configuration.

## Structure
- Shared package mips_rf_pkg holds:
  - the dump FSM state enum (IDLE, STREAM, DONE);
  - the default DATA_W and ADDR_W localparams;
  - a function returning the winning write port for a given index.
- Sub-module mips_rf_dump_fsm holds the state register, the dump_idx counter and the handshake outputs. It receives storage read data through a dedicated internal read port and drives the dump_data capture enable.
- The top level holds storage, write arbitration, read muxes and the bypass logic.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and 0x1234 to r0, and read r5/r0 the next cycle: expect 0xDEADBEEF and 0.
- NUM_WR=2, both ports write r7 with 0x11 (port 0) and 0x22 (port 1): r7 reads 0x22 the next cycle.
- Same-cycle write of 0xA5A5A5A5 to r3 while reading r3: expect 0xA5A5A5A5 with RF_BYPASS_EN, and the old value without it.
- Preload r[i]=i*3, pulse dump_req, hold dump_ready=1: expect words 0,3,…,93 on idx 0..31, then dump_done at cycle 34.
- During a dump, drop dump_ready for 5 cycles at idx 10: idx and data are held. Meanwhile write r10=0xFF: 10 is still presented as 30. Write r20=0xEE: 20 is presented as 0xEE.
- Assert rst_b=0 at idx 12 mid-dump: dump_valid and dump_busy drop asynchronously, no dump_done. A new dump_req after reset restarts at idx 0 with all words 0.
